cory_s2p: RTL and testbench



---
 rtl/cory_s2p_pkg.sv | 19 +
 rtl/cory_s2p.sv | 94 +++++++++
 tb/tb_cory_s2p.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cory_s2p_pkg.sv
// Shared helpers for the cory narrow/wide stream converters: ratio legality and
// the slot-index width derived from the ratio.
package cory_s2p_pkg;

  function automatic bit cory_ratio_legal(input int r);
    return (r == 2) || (r == 4) || (r == 8) || (r == 16);
  endfunction

  function automatic int cory_slot_bits(input int r);
    case (r)
      2:       return 1;
      4:       return 2;
      8:       return 3;
      16:      return 4;
      default: return 1;
    endcase
  endfunction

endpackage

// File: rtl/cory_s2p.sv
// Narrow-to-wide gatherer: packs R consecutive N-bit beats into one N*R-bit word,
// with optional early termination (i_a_l) producing a partial word plus slot mask.
module cory_s2p
  import cory_s2p_pkg::*;
#(
  parameter int N  = 8,
  parameter int R  = 2,
  parameter int A  = N,
  parameter int Z  = N * R,
  parameter int BS = cory_slot_bits(R)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_a_v,
  input  logic [A-1:0]  i_a_d,
  input  logic          i_a_l,
  output logic          o_a_r,
  output logic [BS-1:0] o_a_s,
  output logic          o_z_v,
  output logic [Z-1:0]  o_z_d,
  output logic [R-1:0]  o_z_m,
  input  logic          i_z_r
);

  // An unsupported ratio stops elaboration instead of building a broken counter.
  if (!cory_ratio_legal(R)) begin : g_bad_ratio
    $error("cory_s2p: unsupported ratio R=%0d (legal: 2, 4, 8, 16)", R);
  end

  logic [BS-1:0] r_sel;
  logic [Z-1:0]  r_acc;
  logic [R-1:0]  r_mask;
  logic          r_z_v;
  logic [Z-1:0]  r_z_d;
  logic [R-1:0]  r_z_m;

  logic          w_a_acc;
  logic          w_close;
  logic          w_z_xfer;
  logic [Z-1:0]  w_acc_next;
  logic [R-1:0]  w_mask_next;

  assign o_a_r    = !r_z_v || i_z_r;
  assign w_a_acc  = i_a_v && o_a_r;
  assign w_z_xfer = r_z_v && i_z_r;
  assign w_close  = w_a_acc && ((r_sel == BS'(R - 1)) || i_a_l);

  assign o_a_s = r_sel;
  assign o_z_v = r_z_v;
  assign o_z_d = r_z_d;
  assign o_z_m = r_z_m;

  // Accumulator and mask with the incoming beat merged into the current slot.
  always_comb begin
    w_acc_next                 = r_acc;
    w_acc_next[r_sel*N +: N]   = i_a_d;
    w_mask_next                = r_mask;
    w_mask_next[r_sel]         = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel  <= '0;
      r_acc  <= '0;
      r_mask <= '0;
    end else if (w_a_acc) begin
      if (w_close) begin
        r_sel  <= '0;
        r_acc  <= '0;
        r_mask <= '0;
      end else begin
        r_sel  <= r_sel + 1'b1;
        r_acc  <= w_acc_next;
        r_mask <= w_mask_next;
      end
    end
  end

  // A close can only happen while o_a_r is high, so it never overwrites a stalled word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_z_v <= 1'b0;
      r_z_d <= '0;
      r_z_m <= '0;
    end else if (w_close) begin
      r_z_v <= 1'b1;
      r_z_d <= w_acc_next;
      r_z_m <= w_mask_next;
    end else if (w_z_xfer) begin
      r_z_v <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cory_s2p.sv
// Directed bench for cory_s2p (N=8, R=4): vector table plus hand-written
// sequences for stalls, mid-word reset and back-to-back closes.
module tb_cory_s2p;

  localparam int N = 8;
  localparam int R = 4;
  localparam int Z = N * R;

  logic          clk;
  logic          reset_n;
  logic          i_a_v;
  logic [N-1:0]  i_a_d;
  logic          i_a_l;
  logic          o_a_r;
  logic [1:0]    o_a_s;
  logic          o_z_v;
  logic [Z-1:0]  o_z_d;
  logic [R-1:0]  o_z_m;
  logic          i_z_r;

  int total = 0;
  int bad   = 0;

  cory_s2p #(.N(N), .R(R)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .i_a_v  (i_a_v),
    .i_a_d  (i_a_d),
    .i_a_l  (i_a_l),
    .o_a_r  (o_a_r),
    .o_a_s  (o_a_s),
    .o_z_v  (o_z_v),
    .o_z_d  (o_z_d),
    .o_z_m  (o_z_m),
    .i_z_r  (i_z_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        zr;
    logic        exp_ar;
    logic [1:0]  exp_s;
    logic        exp_zv;
    logic [31:0] exp_zd;
    logic [3:0]  exp_zm;
  } vec_t;

  vec_t vecs[15];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l, input logic zr);
    i_a_v = v;
    i_a_d = d;
    i_a_l = l;
    i_z_r = zr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset_n = 1'b0;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Pushes one beat, checking readiness and slot before the edge.
  task automatic pushBeat(input string name, input logic [7:0] d, input logic l,
                          input logic zr, input logic [1:0] exp_s);
    applyStimulus(1'b1, d, l, zr);
    checkOutput({name, "_ready"}, {31'd0, o_a_r}, 32'd1);
    checkOutput({name, "_slot"}, {30'd0, o_a_s}, {30'd0, exp_s});
    tick();
  endtask

  task automatic checkWord(input string name, input logic [31:0] exp_d, input logic [3:0] exp_m);
    checkOutput({name, "_zv"}, {31'd0, o_z_v}, 32'd1);
    checkOutput({name, "_zd"}, o_z_d, exp_d);
    checkOutput({name, "_zm"}, {28'd0, o_z_m}, {28'd0, exp_m});
  endtask

  initial begin
    logic [31:0] held;

    reset_n = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);

    vecs[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0};
    vecs[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0,        4'h0};
    vecs[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0,        4'h0};
    vecs[3]  = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 2'd3, 1'b1, 32'h44332211, 4'hF};
    vecs[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0};
    vecs[5]  = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0};
    vecs[6]  = '{1'b1, 8'hBB, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 32'h0000BBAA, 4'h3};
    vecs[7]  = '{1'b1, 8'hCC, 1'b1, 1'b1, 1'b1, 2'd0, 1'b1, 32'h000000CC, 4'h1};
    vecs[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h000000CC, 4'h1};
    vecs[9]  = '{1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 32'h000000CC, 4'h1};
    vecs[10] = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0};
    vecs[11] = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 32'h0,        4'h0};
    vecs[12] = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 32'h0,        4'h0};
    vecs[13] = '{1'b1, 8'h04, 1'b1, 1'b1, 1'b1, 2'd3, 1'b1, 32'h04030201, 4'hF};
    vecs[14] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0};

    #2;
    checkOutput("rst_zv", {31'd0, o_z_v}, 32'd0);
    checkOutput("rst_zd", o_z_d, 32'd0);
    checkOutput("rst_zm", {28'd0, o_z_m}, 32'd0);
    checkOutput("rst_s", {30'd0, o_a_s}, 32'd0);
    checkOutput("rst_ar", {31'd0, o_a_r}, 32'd1);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 15; i++) begin
      applyStimulus(vecs[i].v, vecs[i].d, vecs[i].l, vecs[i].zr);
      checkOutput($sformatf("vec%0d_ar", i), {31'd0, o_a_r}, {31'd0, vecs[i].exp_ar});
      checkOutput($sformatf("vec%0d_s", i), {30'd0, o_a_s}, {30'd0, vecs[i].exp_s});
      tick();
      checkOutput($sformatf("vec%0d_zv", i), {31'd0, o_z_v}, {31'd0, vecs[i].exp_zv});
      if (vecs[i].exp_zv) begin
        checkOutput($sformatf("vec%0d_zd", i), o_z_d, vecs[i].exp_zd);
        checkOutput($sformatf("vec%0d_zm", i), {28'd0, o_z_m}, {28'd0, vecs[i].exp_zm});
      end
    end

    // Continuous stream: 12 beats, ready never drops, words back to back.
    for (int i = 1; i <= 12; i++) begin
      pushBeat($sformatf("cont%0d", i), 8'(i), 1'b0, 1'b1, 2'((i - 1) % 4));
      if (i % 4 == 0) begin
        checkWord($sformatf("cont_word%0d", i / 4),
                  {8'(i), 8'(i - 1), 8'(i - 2), 8'(i - 3)}, 4'hF);
      end else begin
        checkOutput($sformatf("cont%0d_zv", i), {31'd0, o_z_v}, 32'd0);
      end
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();

    // Stalled full word: input blocked, data held, no beats consumed.
    pushBeat("st1", 8'h11, 1'b0, 1'b0, 2'd0);
    pushBeat("st2", 8'h22, 1'b0, 1'b0, 2'd1);
    pushBeat("st3", 8'h33, 1'b0, 1'b0, 2'd2);
    pushBeat("st4", 8'h44, 1'b0, 1'b0, 2'd3);
    checkWord("st_word", 32'h44332211, 4'hF);
    held = o_z_d;
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b1, 8'h99, 1'b0, 1'b0);
      checkOutput($sformatf("stall%0d_ar", c), {31'd0, o_a_r}, 32'd0);
      tick();
      checkOutput($sformatf("stall%0d_zd", c), o_z_d, held);
      checkOutput($sformatf("stall%0d_s", c), {30'd0, o_a_s}, 32'd0);
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    checkOutput("release_ar", {31'd0, o_a_r}, 32'd1);
    tick();
    checkOutput("release_zv", {31'd0, o_z_v}, 32'd0);

    // Reset mid-word discards the partial beats.
    pushBeat("mr1", 8'h01, 1'b0, 1'b1, 2'd0);
    pushBeat("mr2", 8'h02, 1'b0, 1'b1, 2'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    reset_n = 1'b0;
    #1;
    checkOutput("mr_rst_s", {30'd0, o_a_s}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    pushBeat("mr5", 8'h05, 1'b0, 1'b1, 2'd0);
    pushBeat("mr6", 8'h06, 1'b0, 1'b1, 2'd1);
    pushBeat("mr7", 8'h07, 1'b0, 1'b1, 2'd2);
    pushBeat("mr8", 8'h08, 1'b0, 1'b1, 2'd3);
    checkWord("mr_word", 32'h08070605, 4'hF);

    // Stall released in the same cycle a closing beat is accepted: no bubble.
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    tick();
    checkWord("bb_hold", 32'h08070605, 4'hF);
    pushBeat("bb_close", 8'h5A, 1'b1, 1'b1, 2'd0);
    checkWord("bb_word", 32'h0000005A, 4'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("bb_drain_zv", {31'd0, o_z_v}, 32'd0);

    // Reset while a word is pending loses it.
    pushBeat("rp1", 8'h77, 1'b1, 1'b0, 2'd0);
    checkWord("rp_word", 32'h00000077, 4'h1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    doReset();
    checkOutput("rp_zv", {31'd0, o_z_v}, 32'd0);
    checkOutput("rp_zd", o_z_d, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
